// File: rtl/uart_pkg.sv
// Shared constants and scheduler state encoding for the UART baud scheduler.
// Optional fractional divisor support is selected with BAUD_FRAC_EN.
package uart_pkg;

    localparam int DIV_W       = 11;
    localparam int OVS         = 16;
    localparam int DEFAULT_DIV = 650;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } sched_state_t;

endpackage

// File: rtl/uart_baud_sched_if.sv
// Divisor configuration handshake: cfg_div (and cfg_frac when BAUD_FRAC_EN is set)
// transfers on a rising edge with cfg_valid && cfg_ready.
interface uart_baud_sched_if #(
    parameter int DIV_W = uart_pkg::DIV_W
) ();

    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
`ifdef BAUD_FRAC_EN
    logic [3:0]       cfg_frac;
`endif

    modport master (
        output cfg_valid,
        output cfg_div,
`ifdef BAUD_FRAC_EN
        output cfg_frac,
`endif
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
`ifdef BAUD_FRAC_EN
        input  cfg_frac,
`endif
        output cfg_ready
    );

endinterface

// File: rtl/baud_div_counter.sv
// Divisor counter: counts 0..lim and flags terminal count; with BAUD_FRAC_EN a
// 4-bit phase accumulator stretches the period after each accumulator carry.
module baud_div_counter #(
    parameter int DIV_W = 11
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             run,
    input  logic [DIV_W-1:0] lim,
`ifdef BAUD_FRAC_EN
    input  logic [3:0]       frac,
`endif
    output logic             tc
);

    // One extra bit so lim+1 (frac stretch) cannot overflow the compare.
    logic [DIV_W:0] cnt_q, cnt_d, lim_eff;
`ifdef BAUD_FRAC_EN
    logic [3:0] acc_q, acc_d;
    logic       ext_q, ext_d;
    logic [4:0] acc_sum;
`endif

    always_comb begin
`ifdef BAUD_FRAC_EN
        lim_eff = {1'b0, lim} + {{DIV_W{1'b0}}, ext_q};
        acc_sum = {1'b0, acc_q} + {1'b0, frac};
`else
        lim_eff = {1'b0, lim};
`endif
        tc    = run && (cnt_q == lim_eff);
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tc ? '0 : cnt_q + (DIV_W+1)'(1);
        end
`ifdef BAUD_FRAC_EN
        acc_d = acc_q;
        ext_d = ext_q;
        if (clear) begin
            acc_d = '0;
            ext_d = 1'b0;
        end else if (tc) begin
            acc_d = acc_sum[3:0];
            ext_d = acc_sum[4];
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
`ifdef BAUD_FRAC_EN
            acc_q <= '0;
            ext_q <= 1'b0;
`endif
        end else begin
            cnt_q <= cnt_d;
`ifdef BAUD_FRAC_EN
            acc_q <= acc_d;
            ext_q <= ext_d;
`endif
        end
    end

endmodule

// File: rtl/uart_baud_sched.sv
// Baud scheduler: owns the divisor, emits s_tick (oversample) and tx_tick (bit) pulses.
// New divisors are parked in PEND and only take effect on a tick boundary. Option: BAUD_FRAC_EN.
module uart_baud_sched import uart_pkg::*; #(
    parameter int DIV_W       = uart_pkg::DIV_W,
    parameter int OVS         = uart_pkg::OVS,
    parameter int DEFAULT_DIV = uart_pkg::DEFAULT_DIV
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    uart_baud_sched_if.slave  cfg,
    output logic              s_tick,
    output logic              tx_tick,
    output logic [DIV_W-1:0]  cur_div,
    output logic              running
);

    localparam int OS_W = (OVS > 1) ? $clog2(OVS) : 1;

    sched_state_t     state_q, state_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
`ifdef BAUD_FRAC_EN
    logic [3:0]       cur_frac_q, cur_frac_d;
    logic [3:0]       pend_frac_q, pend_frac_d;
`endif
    logic             xfer;
    logic             tc;

    assign running       = (state_q != OFF);
    assign cfg.cfg_ready = (state_q != PEND);
    assign xfer          = cfg.cfg_valid && cfg.cfg_ready;
    assign s_tick        = running && tc;
    assign tx_tick       = s_tick && (os_cnt_q == OS_W'(OVS - 1));
    assign cur_div       = cur_div_q;

    baud_div_counter #(.DIV_W(DIV_W)) u_div_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!en || (state_q == OFF)),
        .run     (running),
        .lim     (cur_div_q),
`ifdef BAUD_FRAC_EN
        .frac    (cur_frac_q),
`endif
        .tc      (tc)
    );

    always_comb begin
        state_d    = state_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        os_cnt_d   = os_cnt_q;
`ifdef BAUD_FRAC_EN
        cur_frac_d  = cur_frac_q;
        pend_frac_d = pend_frac_q;
`endif
        if (!en) begin
            os_cnt_d = '0;
        end else if (s_tick) begin
            os_cnt_d = tx_tick ? '0 : os_cnt_q + OS_W'(1);
        end

        case (state_q)
            OFF: begin
                if (xfer) begin
                    cur_div_d = cfg.cfg_div;
`ifdef BAUD_FRAC_EN
                    cur_frac_d = cfg.cfg_frac;
`endif
                end
                if (en) state_d = RUN;
            end
            RUN: begin
                // Disable beats a simultaneous config: it lands directly in cur_div.
                if (!en) begin
                    state_d = OFF;
                    if (xfer) begin
                        cur_div_d = cfg.cfg_div;
`ifdef BAUD_FRAC_EN
                        cur_frac_d = cfg.cfg_frac;
`endif
                    end
                end else if (xfer) begin
                    pend_div_d = cfg.cfg_div;
`ifdef BAUD_FRAC_EN
                    pend_frac_d = cfg.cfg_frac;
`endif
                    state_d = PEND;
                end
            end
            PEND: begin
                if (!en || s_tick) begin
                    cur_div_d = pend_div_q;
`ifdef BAUD_FRAC_EN
                    cur_frac_d = pend_frac_q;
`endif
                    state_d = en ? RUN : OFF;
                end
            end
            default: state_d = OFF;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= OFF;
            cur_div_q  <= DIV_W'(DEFAULT_DIV);
            pend_div_q <= '0;
            os_cnt_q   <= '0;
`ifdef BAUD_FRAC_EN
            cur_frac_q  <= '0;
            pend_frac_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            os_cnt_q   <= os_cnt_d;
`ifdef BAUD_FRAC_EN
            cur_frac_q  <= cur_frac_d;
            pend_frac_q <= pend_frac_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_baud_sched.sv
// Bench for uart_baud_sched: expected tick periods are queued as stimulus is
// applied and popped as s_tick pulses appear; tx_tick is checked against a local phase count.
module tb_uart_baud_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic        s_tick, tx_tick, running;
    logic [10:0] cur_div;

    uart_baud_sched_if #(.DIV_W(11)) cfg_if ();

    uart_baud_sched dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .cfg     (cfg_if.slave),
        .s_tick  (s_tick),
        .tx_tick (tx_tick),
        .cur_div (cur_div),
        .running (running)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int s_exp[$];
    int last_s  = 0;
    int last_tx = 0;
    int prev_tx = 0;
    int os_m    = 0;
    int c0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Pops one expected period per observed s_tick; bounded wait per tick.
    task automatic drain(input string tag);
        int  per;
        bit  seen;
        while (s_exp.size() > 0) begin
            seen = 1'b0;
            for (int i = 0; i < 20000 && !seen; i++) begin
                @(negedge clk);
                if (s_tick === 1'b1) seen = 1'b1;
            end
            chk_eq({tag, "_seen"}, 32'(seen), 32'd1);
            if (!seen) begin
                s_exp.delete();
            end else begin
                per    = cyc - last_s;
                last_s = cyc;
                chk_eq(tag, per, s_exp.pop_front());
                chk_eq({tag, "_tx"}, 32'(tx_tick), 32'(os_m == 15));
                if (tx_tick === 1'b1) begin
                    prev_tx = last_tx;
                    last_tx = cyc;
                end
                os_m = (os_m + 1) % 16;
            end
        end
    endtask

    task automatic offer(input logic [10:0] d);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = d;
    endtask

    task automatic start_run();
        en     = 1'b1;
        last_s = cyc;
        os_m   = 0;
    endtask

    initial begin
        reset_n          = 1'b0;
        en               = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div   = '0;
`ifdef BAUD_FRAC_EN
        cfg_if.cfg_frac  = '0;
`endif
        repeat (2) @(negedge clk);
        chk_eq("rst_s_tick", 32'(s_tick), 32'd0);
        chk_eq("rst_tx_tick", 32'(tx_tick), 32'd0);
        chk_eq("rst_running", 32'(running), 32'd0);
        chk_eq("rst_cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
        chk_eq("rst_cur_div", 32'(cur_div), 32'd650);
        reset_n = 1'b1;
        @(negedge clk);

        // Default divisor: 651-cycle s_tick, tx_tick every 16 s_ticks.
        c0 = cyc;
        start_run();
        repeat (16) s_exp.push_back(651);
        drain("def_per");
        chk_eq("def_tx_first", 32'(last_tx - c0), 32'd10416);
        repeat (16) s_exp.push_back(651);
        drain("def_per2");
        chk_eq("def_tx_per", 32'(last_tx - prev_tx), 32'd10416);
        chk_eq("def_cur_div", 32'(cur_div), 32'd650);
        en = 1'b0;
        @(negedge clk);
        chk_eq("off_s_tick", 32'(s_tick), 32'd0);
        chk_eq("off_running", 32'(running), 32'd0);

        // Config while OFF goes straight to cur_div.
        offer(11'd9);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        chk_eq("off_cfg_div", 32'(cur_div), 32'd9);
        chk_eq("off_ready", 32'(cfg_if.cfg_ready), 32'd1);
        start_run();
        s_exp.push_back(10);
        s_exp.push_back(10);
        drain("d9_per");

        // Mid-period config parks in PEND; a held offer waits until PEND exits.
        repeat (2) @(negedge clk);
        offer(11'd4);
        @(negedge clk);
        chk_eq("pend_ready", 32'(cfg_if.cfg_ready), 32'd0);
        chk_eq("pend_cur_old", 32'(cur_div), 32'd9);
        chk_eq("pend_running", 32'(running), 32'd1);
        cfg_if.cfg_div = 11'd2;
        s_exp.push_back(10);
        drain("pend_per");
        chk_eq("pend_ready_tick", 32'(cfg_if.cfg_ready), 32'd0);
        @(negedge clk);
        chk_eq("commit_cur", 32'(cur_div), 32'd4);
        chk_eq("commit_ready", 32'(cfg_if.cfg_ready), 32'd1);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        chk_eq("held_taken", 32'(cfg_if.cfg_ready), 32'd0);
        chk_eq("held_cur", 32'(cur_div), 32'd4);
        s_exp.push_back(5);
        repeat (14) s_exp.push_back(3);
        drain("new_per");
        chk_eq("new_cur", 32'(cur_div), 32'd2);

        // Disable with simultaneous config: OFF wins, divisor applied directly.
        en = 1'b0;
        offer(11'd0);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        chk_eq("enfall_cfg_run", 32'(running), 32'd0);
        chk_eq("enfall_cfg_cur", 32'(cur_div), 32'd0);
        chk_eq("enfall_cfg_tick", 32'(s_tick), 32'd0);

        // Divisor 0: tick every cycle, bit tick every 16.
        start_run();
        repeat (32) s_exp.push_back(1);
        drain("d0_per");
        chk_eq("d0_tx_per", 32'(last_tx - prev_tx), 32'd16);
        en = 1'b0;
        @(negedge clk);
        chk_eq("d0_off_s", 32'(s_tick), 32'd0);
        chk_eq("d0_off_tx", 32'(tx_tick), 32'd0);
        chk_eq("d0_off_run", 32'(running), 32'd0);

        // Config accepted on the tick edge applies only at the following tick.
        offer(11'd5);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        start_run();
        s_exp.push_back(6);
        drain("d5_per");
        offer(11'd7);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        chk_eq("tickcfg_ready", 32'(cfg_if.cfg_ready), 32'd0);
        chk_eq("tickcfg_cur", 32'(cur_div), 32'd5);
        s_exp.push_back(6);
        s_exp.push_back(8);
        drain("tickcfg_per");
        chk_eq("tickcfg_new", 32'(cur_div), 32'd7);

        // Disable in PEND commits the pending divisor.
        offer(11'd3);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        chk_eq("pendoff_ready", 32'(cfg_if.cfg_ready), 32'd0);
        en = 1'b0;
        @(negedge clk);
        chk_eq("pendoff_cur", 32'(cur_div), 32'd3);
        chk_eq("pendoff_run", 32'(running), 32'd0);
        chk_eq("pendoff_rdy", 32'(cfg_if.cfg_ready), 32'd1);

        // Asynchronous reset in PEND discards the pending divisor.
        start_run();
        s_exp.push_back(4);
        drain("d3_per");
        offer(11'd12);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        chk_eq("rstpend_ready", 32'(cfg_if.cfg_ready), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk_eq("arst_cur", 32'(cur_div), 32'd650);
        chk_eq("arst_run", 32'(running), 32'd0);
        chk_eq("arst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        chk_eq("arst_s_tick", 32'(s_tick), 32'd0);
        en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_eq("arst_rel_cur", 32'(cur_div), 32'd650);
        start_run();
        s_exp.push_back(651);
        drain("arst_per");
        chk_eq("arst_final_cur", 32'(cur_div), 32'd650);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
